rom_load_ctrl: RTL
==================

Name: rom_load_ctrl

Overview:
- Avalon-MM slave that the NIOS II uses to sequence game ROM loading into the NES PRG/CHR ROM write ports.
- Accepts base address, target select and data bytes, auto-increments the address, and buffers writes in a small FIFO.
- Drains the FIFO to the ROM port at a fixed write-slot rate.
- Holds the NES core in reset for the whole load and releases it only after the last byte has been written.

Parameters:
- FIFO_DEPTH, 8, number of buffered byte writes; power of two, 2 or more.
- WR_CYCLES, 2, clock cycles per ROM write slot; 1 or more.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- AVL_ADDR  in  2  register select.
- AVL_CS  in  1  chip select.
- AVL_WRITE  in  1  write strobe, qualified by AVL_CS.
- AVL_READ  in  1  read strobe, qualified by AVL_CS.
- AVL_WRITEDATA  in  32  write data.
- AVL_READDATA  out  32  read data, registered.
- ROM_ADDR  out  16  ROM write address.
- ROM_DATA  out  8  ROM write byte.
- PRG_ROM_WRITE  out  1  one-cycle PRG write strobe.
- CHR_ROM_WRITE  out  1  one-cycle CHR write strobe.
- NES_HOLD  out  1  high keeps the NES core in reset.
- LOAD_DONE  out  1  one-cycle pulse when a load completes.

Behaviour:
- Reset values (RESET low, asynchronous): every output is 0, state IDLE, FIFO empty, address 0, TARGET 0, count 0, sticky flags 0.
- Register map, all accesses qualified by AVL_CS:
  - Address 0, CTRL (write). Bit0 START, bit1 TARGET (0 = PRG, 1 = CHR), bit2 FINISH. TARGET is latched on every CTRL write.
  - Address 1, BASE (write). Bits [15:0] load the next write address.
  - Address 2, DATA (write). Bits [7:0] push the entry {TARGET, addr, byte}; bits [31:8] are ignored. On an accepted push, addr increments by 1 mod 2^16 (0xFFFF wraps to 0x0000).
  - Address 3, STATUS (read). Bit0 BUSY (FIFO non-empty or a slot in progress), bit1 FULL, bit2 LOADING (state is not IDLE), bit3 OVF (sticky), bit4 ERR (sticky), bits [31:16] byte count (accepted pushes, saturates at 0xFFFF).
  - Reads of addresses 0–2 return 0, except as defined under CHECKSUM_EN.
- Read latency: AVL_READDATA is valid on the cycle after AVL_READ and holds its value until the next read.
- FSM states: IDLE, LOAD, DRAIN.
  - IDLE: NES_HOLD = 0. START moves to LOAD, clears count, OVF and ERR, and sets NES_HOLD on the next cycle. A DATA write is dropped and sets ERR. FINISH is ignored.
  - LOAD: NES_HOLD = 1; DATA pushes are accepted. FINISH moves to DRAIN. START is ignored.
  - DRAIN: NES_HOLD = 1; DATA writes are dropped and set ERR. Once the FIFO is empty and no slot is active, the block returns to IDLE. On that same transition LOAD_DONE pulses for 1 cycle and NES_HOLD falls on the following cycle.
- FIFO rules:
  - A push while FULL is rejected, even if a pop occurs in the same cycle. A rejected push sets OVF and does not advance addr or count.
  - A push and a pop in the same cycle leave the occupancy unchanged.
- Drain engine:
  - When idle and the FIFO is non-empty, it pops one entry and starts a slot.
  - ROM_ADDR and ROM_DATA are driven from registers and hold their values for the whole slot.
  - PRG_ROM_WRITE or CHR_ROM_WRITE (chosen by the entry's TARGET) is high only in the first cycle of the slot.
  - The next pop is allowed in the last slot cycle, which gives 1 write per WR_CYCLES cycles back-to-back.
  - First strobe latency from the DATA write is 2 cycles: cycle N is the push, cycle N+1 the pop, cycle N+2 the strobe.
  - PRG and CHR strobes are never high together.
- A CTRL write with both START and FINISH set in IDLE is treated as START only.
- Reset mid-load: the FIFO is flushed, the slot is aborted, NES_HOLD is released, and no strobe is issued.

Optional Feature:
- Macro: ROM_LOAD_CHECKSUM_EN.
- When defined:
  - A 16-bit running sum (mod 2^16) of all bytes that have actually been strobed to the ROM, cleared by START.
  - Readable at address 1, bits [15:0].
  - It is final once LOADING reads 0.
- When undefined: address 1 reads 0 and there is no checksum logic.

Test Plan:
- Basic PRG load: START, TARGET = 0, BASE = 0x8000, DATA 0x11, 0x22, 0x33, FINISH.
  - PRG strobes at addresses 0x8000–0x8002 with data 0x11/0x22/0x33, spaced WR_CYCLES = 2 apart.
  - CHR_ROM_WRITE stays 0.
  - LOAD_DONE pulses once and NES_HOLD then falls; STATUS count = 3.
- Burst overflow: 10 back-to-back DATA writes with FIFO_DEPTH = 8, WR_CYCLES = 4.
  - Rejected writes set OVF and do not advance addr.
  - The addresses strobed are contiguous, with no gaps and no duplicates.
- Wrap and CHR target: BASE = 0xFFFF, TARGET = 1, DATA 0xAA then 0xBB.
  - CHR strobes at 0xFFFF then 0x0000.
- Protocol errors: DATA write in IDLE, then a DATA write in DRAIN.
  - Neither write produces a strobe; ERR = 1.
  - A following START clears ERR and OVF.
- Async reset: assert RESET low mid-burst while the FIFO holds 4 entries.
  - All outputs go to 0 immediately; after release no strobe appears and STATUS reads 0.
- CHECKSUM_EN build: load bytes 0xFF, 0xFF, 0x02.
  - Address 1 reads 0x0200 after LOADING = 0.

Source files
------------

// File: rtl/rom_load_ctrl.sv
// ============================================================================
//  Module   : rom_load_ctrl
//  Brief    : Avalon-MM slave that sequences game ROM loading into the NES
//             PRG/CHR ROM write ports. Byte writes are address-stamped,
//             buffered in a small FIFO and drained at one write per
//             WR_CYCLES clocks while the NES core is held in reset.
//  Options  : ROM_LOAD_CHECKSUM_EN - adds a 16-bit running sum of the strobed
//             bytes, readable at register address 1.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_load_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int WR_CYCLES  = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  AVL_ADDR,
  input  logic        AVL_CS,
  input  logic        AVL_WRITE,
  input  logic        AVL_READ,
  input  logic [31:0] AVL_WRITEDATA,
  output logic [31:0] AVL_READDATA,
  output logic [15:0] ROM_ADDR,
  output logic [7:0]  ROM_DATA,
  output logic        PRG_ROM_WRITE,
  output logic        CHR_ROM_WRITE,
  output logic        NES_HOLD,
  output logic        LOAD_DONE
);

  localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int c_SLOT_W  = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam int c_ENTRY_W = 25;  // {target, addr[15:0], byte[7:0]}
  localparam logic [c_CNT_W-1:0]  c_FULL      = c_CNT_W'(FIFO_DEPTH);
  localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(WR_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Register state
  logic                 r_target;
  logic [15:0]          r_addr;
  logic [15:0]          r_byte_cnt;
  logic                 r_ovf;
  logic                 r_err;
  logic                 r_nes_hold;
  logic                 r_load_done;
  logic [31:0]          r_readdata;

  // FIFO state
  logic [c_ENTRY_W-1:0] r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;

  // Drain engine state
  logic                 r_slot_active;
  logic [c_SLOT_W-1:0]  r_slot_cnt;
  logic [15:0]          r_rom_addr;
  logic [7:0]           r_rom_data;
  logic                 r_prg_wr;
  logic                 r_chr_wr;

  // Bus decode and control strobes
  logic w_wr;
  logic w_rd;
  logic w_ctrl_wr;
  logic w_base_wr;
  logic w_data_wr;
  logic w_start;
  logic w_finish;
  logic w_push_req;
  logic w_push_ok;
  logic w_push_rej;
  logic w_data_err;
  logic w_full;
  logic w_empty;
  logic w_slot_end;
  logic w_pop;
  logic w_drain_done;
  logic [c_ENTRY_W-1:0] w_head;
  logic [31:0] w_status;
  logic w_unused;

  assign w_wr      = AVL_CS & AVL_WRITE;
  assign w_rd      = AVL_CS & AVL_READ;
  assign w_ctrl_wr = w_wr & (AVL_ADDR == 2'd0);
  assign w_base_wr = w_wr & (AVL_ADDR == 2'd1);
  assign w_data_wr = w_wr & (AVL_ADDR == 2'd2);

  // START only matters in IDLE and FINISH only in LOAD, so START|FINISH in
  // IDLE naturally behaves as START alone.
  assign w_start    = w_ctrl_wr & AVL_WRITEDATA[0] & (r_state == S_IDLE);
  assign w_finish   = w_ctrl_wr & AVL_WRITEDATA[2] & (r_state == S_LOAD);
  assign w_push_req = w_data_wr & (r_state == S_LOAD);
  assign w_data_err = w_data_wr & (r_state != S_LOAD);

  // Full is judged on the registered occupancy, so a push into a full FIFO is
  // refused even when a pop frees a slot in the same cycle.
  assign w_full     = (r_count == c_FULL);
  assign w_empty    = (r_count == '0);
  assign w_push_ok  = w_push_req & ~w_full;
  assign w_push_rej = w_push_req & w_full;

  // The next entry may be popped in the last cycle of the current slot, which
  // keeps back-to-back slots exactly WR_CYCLES apart.
  assign w_slot_end   = r_slot_active & (r_slot_cnt == c_SLOT_LAST);
  assign w_pop        = ~w_empty & (~r_slot_active | w_slot_end);
  assign w_drain_done = (r_state == S_DRAIN) & w_empty & ~r_slot_active;
  assign w_head       = r_mem[r_rd_ptr];

  assign w_status = {r_byte_cnt, 11'd0, r_err, r_ovf, (r_state != S_IDLE),
                     w_full, (~w_empty | r_slot_active)};

  assign w_unused = ^AVL_WRITEDATA[31:16];

  assign AVL_READDATA  = r_readdata;
  assign ROM_ADDR      = r_rom_addr;
  assign ROM_DATA      = r_rom_data;
  assign PRG_ROM_WRITE = r_prg_wr;
  assign CHR_ROM_WRITE = r_chr_wr;
  assign NES_HOLD      = r_nes_hold;
  assign LOAD_DONE     = r_load_done;

  // Load sequencer state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Load sequencer next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start)      w_state_next = S_LOAD;
      S_LOAD:  if (w_finish)     w_state_next = S_DRAIN;
      S_DRAIN: if (w_drain_done) w_state_next = S_IDLE;
      default:                   w_state_next = S_IDLE;
    endcase
  end

  // NES hold and completion pulse; hold tracks the previous state so it drops
  // one cycle after the LOAD_DONE pulse
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_nes_hold  <= 1'b0;
      r_load_done <= 1'b0;
    end else begin
      r_nes_hold  <= w_start | (r_state != S_IDLE);
      r_load_done <= w_drain_done;
    end
  end

  // Control registers: target, auto-incrementing address, count, sticky flags
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_target   <= 1'b0;
      r_addr     <= 16'h0000;
      r_byte_cnt <= 16'h0000;
      r_ovf      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_target <= AVL_WRITEDATA[1];

      if (w_base_wr)      r_addr <= AVL_WRITEDATA[15:0];
      else if (w_push_ok) r_addr <= r_addr + 16'd1;

      if (w_start)                                r_byte_cnt <= 16'h0000;
      else if (w_push_ok && r_byte_cnt != 16'hFFFF) r_byte_cnt <= r_byte_cnt + 16'd1;

      if (w_start)         r_ovf <= 1'b0;
      else if (w_push_rej) r_ovf <= 1'b1;

      if (w_start)         r_err <= 1'b0;
      else if (w_data_err) r_err <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge CLK) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= {r_target, r_addr, AVL_WRITEDATA[7:0]};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push_ok) r_count <= r_count - 1'b1;
    end
  end

  // Drain engine: one ROM write slot per popped entry, strobe in first cycle
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_slot_active <= 1'b0;
      r_slot_cnt    <= '0;
      r_rom_addr    <= 16'h0000;
      r_rom_data    <= 8'h00;
      r_prg_wr      <= 1'b0;
      r_chr_wr      <= 1'b0;
    end else if (w_pop) begin
      r_slot_active <= 1'b1;
      r_slot_cnt    <= '0;
      r_rom_addr    <= w_head[23:8];
      r_rom_data    <= w_head[7:0];
      r_prg_wr      <= ~w_head[24];
      r_chr_wr      <= w_head[24];
    end else begin
      r_prg_wr <= 1'b0;
      r_chr_wr <= 1'b0;
      if (w_slot_end) begin
        r_slot_active <= 1'b0;
        r_slot_cnt    <= '0;
      end else if (r_slot_active) begin
        r_slot_cnt <= r_slot_cnt + 1'b1;
      end
    end
  end

`ifdef ROM_LOAD_CHECKSUM_EN
  logic [15:0] r_csum;

  // Running sum of bytes as they are strobed to the ROM
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                    r_csum <= 16'h0000;
    else if (w_start)              r_csum <= 16'h0000;
    else if (r_prg_wr || r_chr_wr) r_csum <= r_csum + {8'h00, r_rom_data};
  end
`endif

  // Registered read data, held until the next read
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_readdata <= 32'h0000_0000;
    end else if (w_rd) begin
      case (AVL_ADDR)
        2'd3:    r_readdata <= w_status;
`ifdef ROM_LOAD_CHECKSUM_EN
        2'd1:    r_readdata <= {16'h0000, r_csum};
`endif
        default: r_readdata <= 32'h0000_0000;
      endcase
    end
  end

endmodule

`default_nettype wire
